// File: rtl/gem_link_pkg.sv
`timescale 1ns/1ps
// Shared GEM trigger-link definitions: K-codes, frame geometry and separator classes.
package gem_link_pkg;

  localparam logic [7:0] K_BC0    = 8'h1C;
  localparam logic [7:0] K_RESYNC = 8'h3C;
  localparam logic [7:0] K_OVF    = 8'hFC;
  localparam logic [7:0] K_SEQ0   = 8'hBC;
  localparam logic [7:0] K_SEQ1   = 8'hF7;
  localparam logic [7:0] K_SEQ2   = 8'hFB;
  localparam logic [7:0] K_SEQ3   = 8'hFD;
  localparam logic [7:0] K_IDLE   = 8'hDC;

  localparam logic [15:0] IDLE_WORD = {8'hFF, K_IDLE};

  localparam int unsigned FRAME_WORDS  = 4;
  localparam int unsigned WORD_BITS    = 16;
  localparam int unsigned PAYLOAD_BITS = 56;
  localparam int unsigned POS_BITS     = $clog2(FRAME_WORDS);

  typedef enum logic [2:0] {
    SEP_NONE,
    SEP_BC0,
    SEP_RESYNC,
    SEP_OVF,
    SEP_SEQ
  } sep_class_t;

  typedef logic [1:0] seq_idx_t;

  // Classified frame separator as captured from word0.
  typedef struct packed {
    sep_class_t cls;
    seq_idx_t   idx;
    logic       ok;
  } sep_info_t;

  // Map a separator byte to its class; anything else is NONE.
  function automatic sep_class_t sep_class_of(input logic [7:0] code);
    sep_class_t c;
    case (code)
      K_BC0:                          c = SEP_BC0;
      K_RESYNC:                       c = SEP_RESYNC;
      K_OVF:                          c = SEP_OVF;
      K_SEQ0, K_SEQ1, K_SEQ2, K_SEQ3: c = SEP_SEQ;
      default:                        c = SEP_NONE;
    endcase
    return c;
  endfunction

  // Rotation index carried by a BX-sequence separator.
  function automatic seq_idx_t seq_idx_of(input logic [7:0] code);
    seq_idx_t i;
    case (code)
      K_SEQ1:  i = 2'd1;
      K_SEQ2:  i = 2'd2;
      K_SEQ3:  i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/gem_frame_sep_decode.sv
`timescale 1ns/1ps
// Frame-separator classifier: combinational hit/idle detect, registered class/index of word0.
module gem_frame_sep_decode
  import gem_link_pkg::*;
(
  input  logic                 clock_160,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic [WORD_BITS-1:0] rx_data_i,
  input  logic [1:0]           rx_isk_i,
  input  logic                 rx_err_i,
  output sep_info_t            sep_info_o,
  output logic                 sep_hit_c,
  output logic                 idle_c
);

  sep_class_t cls_c;

  // Classify the current word as a possible frame start or idle.
  always_comb begin
    cls_c     = sep_class_of(rx_data_i[7:0]);
    sep_hit_c = (rx_isk_i == 2'b01) && !rx_err_i && (cls_c != SEP_NONE);
    idle_c    = (rx_isk_i == 2'b01) && (rx_data_i == IDLE_WORD);
  end

  // Hold the classification of word0 for the rest of the frame.
  always_ff @(posedge clock_160) begin
    if (!reset_n_i) begin
      sep_info_o <= '0;
    end else if (load_i) begin
      sep_info_o.cls <= cls_c;
      sep_info_o.idx <= seq_idx_of(rx_data_i[7:0]);
      sep_info_o.ok  <= sep_hit_c;
    end
  end

endmodule

// File: rtl/gem_data_in.sv
`timescale 1ns/1ps
// GEM trigger-link receiver: frame lock, payload reassembly, flag decode and link error accounting.
module gem_data_in
  import gem_link_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES  = 8,
  parameter int unsigned UNLOCK_ERRS  = 4,
  parameter int unsigned CHECK_SEQ    = 1,
  parameter int unsigned ERR_CNT_BITS = 16
) (
  input  logic                    clock_160,
  input  logic                    reset_n_i,
  input  logic [WORD_BITS-1:0]    rx_data_i,
  input  logic [1:0]              rx_isk_i,
  input  logic                    rx_err_i,
  output logic [PAYLOAD_BITS-1:0] gem_data_o,
  output logic                    data_valid_o,
  output logic                    bc0_o,
  output logic                    resync_o,
  output logic                    overflow_o,
  output logic [1:0]              bxn_lsbs_o,
  output logic                    locked_o,
  output logic                    seq_err_o,
  output logic [ERR_CNT_BITS-1:0] err_cnt_o
);

  localparam int unsigned GOOD_BITS = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned BAD_BITS  = $clog2(UNLOCK_ERRS + 1);
  localparam int unsigned LOW_BITS  = PAYLOAD_BITS - WORD_BITS;

  typedef enum logic [1:0] {ST_HUNT, ST_SYNCING, ST_LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [POS_BITS-1:0]     pos_q, pos_d;
  logic [GOOD_BITS-1:0]    good_q, good_d;
  logic [BAD_BITS-1:0]     bad_q, bad_d;
  logic                    acc_bad_q, acc_bad_d;
  logic [LOW_BITS-1:0]     pay_q, pay_d;
  seq_idx_t                exp_q, exp_d;

  logic [PAYLOAD_BITS-1:0] data_d;
  logic                    valid_d, bc0_d, resync_d, ovf_d, locked_d, seq_err_d;
  seq_idx_t                bxn_d;
  logic [ERR_CNT_BITS-1:0] err_d;

  sep_info_t               sep_info;
  logic                    sep_hit_c, idle_c, load_c, word_bad_c, frame_bad_c;
  seq_idx_t                frame_idx_c, next_exp_c;

  assign load_c = (state_q == ST_HUNT) || (pos_q == '0);

  gem_frame_sep_decode u_sep_decode (
    .clock_160  (clock_160),
    .reset_n_i  (reset_n_i),
    .load_i     (load_c),
    .rx_data_i  (rx_data_i),
    .rx_isk_i   (rx_isk_i),
    .rx_err_i   (rx_err_i),
    .sep_info_o (sep_info),
    .sep_hit_c  (sep_hit_c),
    .idle_c     (idle_c)
  );

  // Per-word/per-frame validity and BX index bookkeeping for the frame in flight.
  always_comb begin
    word_bad_c  = (rx_isk_i != 2'b00) || rx_err_i;
    frame_bad_c = !sep_info.ok || acc_bad_q || word_bad_c;
    frame_idx_c = (sep_info.cls == SEP_SEQ) ? sep_info.idx : exp_q;
    next_exp_c  = (sep_info.cls == SEP_BC0) ? 2'd1 : seq_idx_t'(frame_idx_c + 2'd1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    good_d    = good_q;
    bad_d     = bad_q;
    acc_bad_d = acc_bad_q;
    pay_d     = pay_q;
    exp_d     = exp_q;
    data_d    = gem_data_o;
    valid_d   = 1'b0;
    bc0_d     = bc0_o;
    resync_d  = resync_o;
    ovf_d     = overflow_o;
    bxn_d     = bxn_lsbs_o;
    seq_err_d = 1'b0;
    err_d     = err_cnt_o;

    case (pos_q)
      2'd0:    pay_d[7:0]   = rx_data_i[15:8];
      2'd1:    pay_d[23:8]  = rx_data_i;
      2'd2:    pay_d[39:24] = rx_data_i;
      default: pay_d        = pay_q;
    endcase

    case (state_q)
      ST_HUNT: begin
        if (sep_hit_c) begin
          state_d   = ST_SYNCING;
          pos_d     = POS_BITS'(1);
          good_d    = GOOD_BITS'(1);
          acc_bad_d = 1'b0;
        end
      end

      ST_SYNCING: begin
        if ((pos_q == '0) ? !sep_hit_c : word_bad_c) begin
          state_d = ST_HUNT;
          pos_d   = '0;
        end else begin
          pos_d = pos_q + POS_BITS'(1);
          if (pos_q == POS_BITS'(FRAME_WORDS - 1)) begin
            exp_d = next_exp_c;
            if (good_q == GOOD_BITS'(LOCK_FRAMES)) begin
              state_d = ST_LOCKED;
              bad_d   = '0;
            end else begin
              good_d = good_q + GOOD_BITS'(1);
            end
          end
        end
      end

      ST_LOCKED: begin
        if ((pos_q == '0) && idle_c) begin
          state_d = ST_HUNT;
          pos_d   = '0;
        end else begin
          pos_d = pos_q + POS_BITS'(1);
          case (pos_q)
            2'd0:       acc_bad_d = 1'b0;
            2'd1, 2'd2: acc_bad_d = acc_bad_q | word_bad_c;
            default: begin
              if (frame_bad_c) begin
                if (err_cnt_o != '1) err_d = err_cnt_o + ERR_CNT_BITS'(1);
                if (bad_q == BAD_BITS'(UNLOCK_ERRS - 1)) begin
                  state_d = ST_HUNT;
                  pos_d   = '0;
                  bad_d   = '0;
                end else begin
                  bad_d = bad_q + BAD_BITS'(1);
                end
              end else begin
                valid_d   = 1'b1;
                data_d    = {rx_data_i, pay_q};
                bc0_d     = (sep_info.cls == SEP_BC0);
                resync_d  = (sep_info.cls == SEP_RESYNC);
                ovf_d     = (sep_info.cls == SEP_OVF);
                bxn_d     = frame_idx_c;
                seq_err_d = (CHECK_SEQ != 0) && (sep_info.cls == SEP_SEQ) &&
                            (sep_info.idx != exp_q);
                exp_d     = next_exp_c;
                bad_d     = '0;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = ST_HUNT;
        pos_d   = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock_160) begin
    if (!reset_n_i) begin
      state_q      <= ST_HUNT;
      pos_q        <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      acc_bad_q    <= 1'b0;
      pay_q        <= '0;
      exp_q        <= '0;
      gem_data_o   <= '0;
      data_valid_o <= 1'b0;
      bc0_o        <= 1'b0;
      resync_o     <= 1'b0;
      overflow_o   <= 1'b0;
      bxn_lsbs_o   <= '0;
      locked_o     <= 1'b0;
      seq_err_o    <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      acc_bad_q    <= acc_bad_d;
      pay_q        <= pay_d;
      exp_q        <= exp_d;
      gem_data_o   <= data_d;
      data_valid_o <= valid_d;
      bc0_o        <= bc0_d;
      resync_o     <= resync_d;
      overflow_o   <= ovf_d;
      bxn_lsbs_o   <= bxn_d;
      locked_o     <= locked_d;
      seq_err_o    <= seq_err_d;
      err_cnt_o    <= err_d;
    end
  end

endmodule

// File: tb/tb_gem_data_in.sv
`timescale 1ns/1ps
// Self-checking bench for gem_data_in using a scoreboard of expected strobed frames.
module tb_gem_data_in;
  import gem_link_pkg::*;

  logic        clock_160 = 1'b0;
  logic        reset_n_i;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_isk_i;
  logic        rx_err_i;
  logic [55:0] gem_data_o;
  logic        data_valid_o, bc0_o, resync_o, overflow_o, locked_o, seq_err_o;
  logic [1:0]  bxn_lsbs_o;
  logic [15:0] err_cnt_o;

  typedef struct packed {
    logic [55:0] data;
    logic        bc0;
    logic        resync;
    logic        ovf;
    logic [1:0]  bxn;
    logic        seq_err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [55:0] P0 = 56'h00112233445566;

  always #3 clock_160 = ~clock_160;

  gem_data_in dut (
    .clock_160    (clock_160),
    .reset_n_i    (reset_n_i),
    .rx_data_i    (rx_data_i),
    .rx_isk_i     (rx_isk_i),
    .rx_err_i     (rx_err_i),
    .gem_data_o   (gem_data_o),
    .data_valid_o (data_valid_o),
    .bc0_o        (bc0_o),
    .resync_o     (resync_o),
    .overflow_o   (overflow_o),
    .bxn_lsbs_o   (bxn_lsbs_o),
    .locked_o     (locked_o),
    .seq_err_o    (seq_err_o),
    .err_cnt_o    (err_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  function automatic logic [7:0] seq_code(input int i);
    logic [7:0] c;
    case (i % 4)
      0:       c = K_SEQ0;
      1:       c = K_SEQ1;
      2:       c = K_SEQ2;
      default: c = K_SEQ3;
    endcase
    return c;
  endfunction

  function automatic logic [55:0] pay_of(input int k);
    return {8'(k), 40'h0123456789, 8'(k ^ 8'h5A)};
  endfunction

  task automatic send_word(input logic [15:0] w, input logic [1:0] k, input logic e);
    rx_data_i = w;
    rx_isk_i  = k;
    rx_err_i  = e;
    @(negedge clock_160);
  endtask

  // bad_word selects which word (0..3) carries rx_err_i; -1 for none.
  task automatic send_frame(input logic [7:0] sep, input logic [55:0] d, input int bad_word);
    send_word({d[7:0], sep}, 2'b01, bad_word == 0);
    send_word(d[23:8],       2'b00, bad_word == 1);
    send_word(d[39:24],      2'b00, bad_word == 2);
    send_word(d[55:40],      2'b00, bad_word == 3);
  endtask

  task automatic good_frame(input logic [7:0] sep, input logic [55:0] d, input logic strobe,
                            input logic [1:0] bxn, input logic se);
    exp_t e;
    if (strobe) begin
      e.data    = d;
      e.bc0     = (sep == K_BC0);
      e.resync  = (sep == K_RESYNC);
      e.ovf     = (sep == K_OVF);
      e.bxn     = bxn;
      e.seq_err = se;
      sb_q.push_back(e);
    end
    send_frame(sep, d, -1);
  endtask

  // Compare every strobed frame against the scoreboard head.
  always @(negedge clock_160) begin
    if (data_valid_o === 1'b1) begin
      chk("strobe_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("gem_data", 64'(gem_data_o), 64'(mon_e.data));
        chk("bc0",      64'(bc0_o),      64'(mon_e.bc0));
        chk("resync",   64'(resync_o),   64'(mon_e.resync));
        chk("overflow", 64'(overflow_o), 64'(mon_e.ovf));
        chk("bxn_lsbs", 64'(bxn_lsbs_o), 64'(mon_e.bxn));
        chk("seq_err",  64'(seq_err_o),  64'(mon_e.seq_err));
      end
    end
    if (seq_err_o === 1'b1) chk("seq_err_aligned", 64'(data_valid_o), 64'd1);
  end

  initial begin
    reset_n_i = 1'b0;
    rx_data_i = IDLE_WORD;
    rx_isk_i  = 2'b01;
    rx_err_i  = 1'b0;
    repeat (3) @(negedge clock_160);
    chk("rst_locked", 64'(locked_o),     64'd0);
    chk("rst_valid",  64'(data_valid_o), 64'd0);
    chk("rst_data",   64'(gem_data_o),   64'd0);
    chk("rst_err",    64'(err_cnt_o),    64'd0);

    // Idle stream never locks.
    reset_n_i = 1'b1;
    for (int i = 0; i < 100; i++) send_word(IDLE_WORD, 2'b01, 1'b0);
    chk("idle_locked", 64'(locked_o),  64'd0);
    chk("idle_err",    64'(err_cnt_o), 64'd0);

    // Lock on the BC/F7/FB/FD rotation.
    for (int i = 0; i < 10; i++) begin
      good_frame(seq_code(i), P0, i >= 8, 2'(i % 4), 1'b0);
      if (i == 6) chk("lock_after7", 64'(locked_o), 64'd0);
      if (i == 7) chk("lock_after8", 64'(locked_o), 64'd1);
      if (i == 8) chk("strobe_latency", 64'(data_valid_o), 64'd1);
    end

    // Flag decode and sequence error with resync (expected index is 2 here).
    good_frame(K_BC0,    pay_of(1), 1'b1, 2'd2, 1'b0);
    good_frame(K_SEQ1,   pay_of(2), 1'b1, 2'd1, 1'b0);
    good_frame(K_SEQ3,   pay_of(3), 1'b1, 2'd3, 1'b1);
    good_frame(K_SEQ0,   pay_of(4), 1'b1, 2'd0, 1'b0);
    good_frame(K_SEQ1,   pay_of(5), 1'b1, 2'd1, 1'b0);
    good_frame(K_RESYNC, pay_of(6), 1'b1, 2'd2, 1'b0);
    good_frame(K_OVF,    pay_of(7), 1'b1, 2'd3, 1'b0);
    good_frame(K_SEQ0,   pay_of(8), 1'b1, 2'd0, 1'b0);

    // Three bad frames stay locked; a good frame clears the bad run.
    for (int i = 0; i < 3; i++) send_frame(seq_code(i + 1), pay_of(20 + i), 2);
    chk("err_cnt_3", 64'(err_cnt_o), 64'd3);
    chk("locked_3",  64'(locked_o),  64'd1);
    good_frame(K_SEQ1, pay_of(30), 1'b1, 2'd1, 1'b0);

    // Four bad frames unlock, then relock after LOCK_FRAMES good frames.
    for (int i = 0; i < 4; i++) begin
      send_frame(seq_code(i + 2), pay_of(40 + i), 2);
      chk("unlock_run", 64'(locked_o), (i == 3) ? 64'd0 : 64'd1);
    end
    chk("err_cnt_7", 64'(err_cnt_o), 64'd7);
    for (int i = 0; i < 8; i++) begin
      good_frame(seq_code(i), pay_of(50 + i), 1'b0, 2'd0, 1'b0);
      if (i == 6) chk("relock_after7", 64'(locked_o), 64'd0);
      if (i == 7) chk("relock_after8", 64'(locked_o), 64'd1);
    end
    good_frame(K_SEQ0, pay_of(60), 1'b1, 2'd0, 1'b0);
    chk("err_cnt_hold", 64'(err_cnt_o), 64'd7);

    // Idle at a frame boundary drops lock without counting.
    send_word(IDLE_WORD, 2'b01, 1'b0);
    chk("idle_unlock",  64'(locked_o),  64'd0);
    chk("idle_err_cnt", 64'(err_cnt_o), 64'd7);
    repeat (5) send_word(IDLE_WORD, 2'b01, 1'b0);

    // Misaligned start with a spurious K on word2 must be rejected.
    send_word({8'h55, K_SEQ0}, 2'b01, 1'b0);
    send_word(16'h1234, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      good_frame(seq_code(i), pay_of(70 + i), 1'b0, 2'd0, 1'b0);
      if (i == 7) chk("misalign_not_locked", 64'(locked_o), 64'd0);
      if (i == 8) chk("misalign_locked",     64'(locked_o), 64'd1);
    end
    good_frame(K_SEQ1, pay_of(80), 1'b1, 2'd1, 1'b0);

    // Reset at word2 of a locked frame clears everything.
    send_word({8'hAA, K_SEQ2}, 2'b01, 1'b0);
    send_word(16'hBBCC, 2'b00, 1'b0);
    reset_n_i = 1'b0;
    send_word(16'hDDEE, 2'b00, 1'b0);
    chk("mid_rst_locked", 64'(locked_o),     64'd0);
    chk("mid_rst_data",   64'(gem_data_o),   64'd0);
    chk("mid_rst_err",    64'(err_cnt_o),    64'd0);
    chk("mid_rst_flags",  64'({bc0_o, resync_o, overflow_o, bxn_lsbs_o, seq_err_o, data_valid_o}), 64'd0);
    reset_n_i = 1'b1;
    send_word(16'h0F0F, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      good_frame(seq_code(i), pay_of(90 + i), 1'b0, 2'd0, 1'b0);
      if (i == 6) chk("rst_relock_after7", 64'(locked_o), 64'd0);
      if (i == 7) chk("rst_relock_after8", 64'(locked_o), 64'd1);
    end
    chk("rst_relock_err", 64'(err_cnt_o), 64'd0);
    good_frame(K_SEQ0, pay_of(99), 1'b1, 2'd0, 1'b0);

    repeat (4) send_word(IDLE_WORD, 2'b01, 1'b0);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
